// File: rtl/seven_segment_decoder.sv
// Rebuilds the 16-bit hex value and decimal points from multiplexed active-low
// anode/segment pins; each digit is captured once its pattern has settled.
module seven_segment_decoder #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  anode,
    input  logic [7:0]  segment,
    output logic [15:0] dataOut,
    output logic [3:0]  pointOut,
    output logic        frameValid,
    output logic        decodeError
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_STROBE = CW'(STABLE_CYCLES - 2);

    logic [3:0]    s_an_q, p_an_q;
    logic [7:0]    s_seg_q, p_seg_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   nib_q, nib_d;
    logic [3:0]    dp_q, dp_d;
    logic          done_q, done_d;
    logic [15:0]   data_q, data_d;
    logic [3:0]    point_q, point_d;
    logic          fv_q, err_q, err_d;

    logic       same, strobe, blank, pat_ok, capture_ok;
    logic [3:0] sel, nib_val, seen_base;
    logic [6:0] pat;

    always_comb begin
        same   = ({s_an_q, s_seg_q} == {p_an_q, p_seg_q});
        cnt_d  = !same ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
        strobe = same && (cnt_q == CNT_STROBE);
        blank  = (s_an_q == 4'hF);
        pat    = ~s_seg_q[6:0];

        pat_ok  = 1'b1;
        nib_val = 4'h0;
        case (pat)
            7'h3F: nib_val = 4'h0;
            7'h06: nib_val = 4'h1;
            7'h5B: nib_val = 4'h2;
            7'h4F: nib_val = 4'h3;
            7'h66: nib_val = 4'h4;
            7'h6D: nib_val = 4'h5;
            7'h7D: nib_val = 4'h6;
            7'h07: nib_val = 4'h7;
            7'h7F: nib_val = 4'h8;
            7'h6F: nib_val = 4'h9;
            7'h77: nib_val = 4'hA;
            7'h7C: nib_val = 4'hB;
            7'h39: nib_val = 4'hC;
            7'h5E: nib_val = 4'hD;
            7'h79: nib_val = 4'hE;
            7'h71: nib_val = 4'hF;
            default: pat_ok = 1'b0;
        endcase

        case (s_an_q)
            4'b1110: sel = 4'b0001;
            4'b1101: sel = 4'b0010;
            4'b1011: sel = 4'b0100;
            4'b0111: sel = 4'b1000;
            default: sel = 4'b0000;
        endcase

        // A completed frame clears seen on the same edge a new capture may land.
        seen_base  = done_q ? '0 : seen_q;
        capture_ok = strobe && (sel != 4'b0000) && pat_ok;
        seen_d     = capture_ok ? (seen_base | sel) : seen_base;
        done_d     = capture_ok && (seen_d == 4'hF);
        err_d      = strobe && !blank && ((sel == 4'b0000) || !pat_ok);

        nib_d = nib_q;
        dp_d  = dp_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (capture_ok && sel[i]) begin
                nib_d[4*i +: 4] = nib_val;
                dp_d[i]         = ~s_seg_q[7];
            end
        end

        data_d  = done_q ? nib_q : data_q;
        point_d = done_q ? dp_q  : point_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_an_q  <= 4'hF;
            s_seg_q <= 8'hFF;
            p_an_q  <= 4'hF;
            p_seg_q <= 8'hFF;
            cnt_q   <= '0;
            seen_q  <= '0;
            nib_q   <= '0;
            dp_q    <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
            point_q <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s_an_q  <= anode;
            s_seg_q <= segment;
            p_an_q  <= s_an_q;
            p_seg_q <= s_seg_q;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            nib_q   <= nib_d;
            dp_q    <= dp_d;
            done_q  <= done_d;
            data_q  <= data_d;
            point_q <= point_d;
            fv_q    <= done_q;
            err_q   <= err_d;
        end
    end

    assign dataOut     = data_q;
    assign pointOut    = point_q;
    assign frameValid  = fv_q;
    assign decodeError = err_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Drives scanned digit patterns into seven_segment_decoder and compares each
// reported frame against a queue of expected frames.
module tb_seven_segment_decoder;

    localparam int unsigned S = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  anode;
    logic [7:0]  segment;
    logic [15:0] dataOut;
    logic [3:0]  pointOut;
    logic        frameValid;
    logic        decodeError;

    int checks = 0;
    int failures = 0;
    int fv_cnt = 0;
    int err_cnt = 0;
    int exp_frames = 0;
    logic [19:0] exp_q[$];

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        int unsigned dwell;
        logic [7:0]  order;
    } vec_t;

    vec_t vecs[8];

    seven_segment_decoder #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .anode(anode), .segment(segment),
        .dataOut(dataOut), .pointOut(pointOut),
        .frameValid(frameValid), .decodeError(decodeError)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'h3F;  4'h1: enc = 7'h06;  4'h2: enc = 7'h5B;  4'h3: enc = 7'h4F;
            4'h4: enc = 7'h66;  4'h5: enc = 7'h6D;  4'h6: enc = 7'h7D;  4'h7: enc = 7'h07;
            4'h8: enc = 7'h7F;  4'h9: enc = 7'h6F;  4'hA: enc = 7'h77;  4'hB: enc = 7'h7C;
            4'hC: enc = 7'h39;  4'hD: enc = 7'h5E;  4'hE: enc = 7'h79;  default: enc = 7'h71;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_digit(input int unsigned idx, input logic [3:0] nib, input logic dp);
        logic [3:0] one;
        one     = 4'b0001;
        anode   = ~(one << idx);
        segment = {~dp, ~enc(nib)};
    endtask

    task automatic drive_digit(input int unsigned idx, input logic [15:0] data,
                               input logic [3:0] dp, input int unsigned cycles);
        @(negedge clk);
        set_digit(idx, data[4*idx +: 4], dp[idx]);
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic blank(input int unsigned cycles);
        @(negedge clk);
        anode   = 4'hF;
        segment = 8'hFF;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [15:0] data, input logic [3:0] dp);
        exp_q.push_back({data, dp});
        exp_frames++;
    endtask

    always @(negedge clk) begin : mon
        logic [19:0] e;
        if (frameValid === 1'b1) begin
            fv_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_frame actual data=%h dp=%b required none", dataOut, pointOut);
            end else begin
                e = exp_q.pop_front();
                if ({dataOut, pointOut} !== e) begin
                    failures++;
                    $display("FAIL frame_data actual data=%h dp=%b required data=%h dp=%b",
                             dataOut, pointOut, e[19:4], e[3:0]);
                end
            end
        end
        if (decodeError === 1'b1) err_cnt++;
    end

    initial begin
        int bad, fv0, e0, first;
        logic [1:0] idx;

        vecs[0] = '{16'h12AF, 4'b0100, 100, 8'b11_10_01_00};
        vecs[1] = '{16'h3456, 4'b1010, 30,  8'b10_00_01_11};
        vecs[2] = '{16'h789A, 4'b0001, 25,  8'b00_01_10_11};
        vecs[3] = '{16'hBCDE, 4'b1111, S,   8'b11_10_01_00};
        vecs[4] = '{16'hF012, 4'b0000, 40,  8'b01_11_00_10};
        vecs[5] = '{16'h9034, 4'b0100, 20,  8'b11_10_01_00};
        vecs[6] = '{16'h9034, 4'b0100, 20,  8'b11_10_01_00};
        vecs[7] = '{16'h9034, 4'b0100, 20,  8'b11_10_01_00};

        // Reset then a long idle blank period.
        reset = 1'b0; anode = 4'hF; segment = 8'hFF;
        repeat (5) @(negedge clk);
        check("reset_outputs", {dataOut, pointOut, frameValid, decodeError}, '0);
        reset = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({dataOut, pointOut, frameValid, decodeError} !== '0) bad++;
        end
        check("idle_outputs_zero", bad, 0);
        check("idle_no_pulses", fv_cnt + err_cnt, 0);

        // Table of scanned frames, including minimal dwell and a continuous loopback scan.
        foreach (vecs[v]) begin
            expect_frame(vecs[v].data, vecs[v].dp);
            for (int k = 0; k < 4; k++) begin
                idx = vecs[v].order[2*k +: 2];
                drive_digit(idx, vecs[v].data, vecs[v].dp, vecs[v].dwell);
            end
        end
        blank(S + 10);
        check("table_frames", fv_cnt, exp_frames);

        // Digit 0 held one cycle short of stable must not count as seen.
        fv0 = fv_cnt;
        @(negedge clk);
        set_digit(0, 4'h7, 1'b0);
        repeat (S - 2) @(negedge clk);
        blank(30);
        drive_digit(1, 16'h5E3C, 4'b0001, 30);
        drive_digit(2, 16'h5E3C, 4'b0001, 30);
        drive_digit(3, 16'h5E3C, 4'b0001, 30);
        check("short_hold_no_frame", fv_cnt, fv0);
        expect_frame(16'h5E3C, 4'b0001);
        @(negedge clk);
        set_digit(0, 4'hC, 1'b1);
        first = 0;
        for (int k = 1; k <= int'(S) + 10; k++) begin
            @(negedge clk);
            if (frameValid === 1'b1 && first == 0) first = k;
        end
        check("frame_latency", first, S + 2);
        blank(20);

        // All segments off on a single digit is an illegal pattern.
        fv0 = fv_cnt; e0 = err_cnt;
        @(negedge clk);
        anode = 4'b1110; segment = 8'hFF;
        first = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (decodeError === 1'b1 && first == 0) first = k;
        end
        check("blank_seg_err_count", err_cnt - e0, 1);
        check("blank_seg_err_time", first, S + 1);
        check("blank_seg_no_frame", fv_cnt, fv0);
        blank(20);

        // Two digits enabled at once: error, and seen must stay unchanged.
        drive_digit(2, 16'hD0B0, 4'b1000, 30);
        drive_digit(3, 16'hD0B0, 4'b1000, 30);
        e0 = err_cnt; fv0 = fv_cnt;
        @(negedge clk);
        anode = 4'b1100; segment = {1'b1, ~enc(4'h8)};
        repeat (99) @(negedge clk);
        check("multi_anode_err", err_cnt - e0, 1);
        drive_digit(0, 16'hD0B0, 4'b1000, 30);
        check("multi_anode_seen_kept", fv_cnt, fv0);
        expect_frame(16'hD0B0, 4'b1000);
        drive_digit(1, 16'hD0B0, 4'b1000, 30);
        blank(20);

        // Reset mid-frame discards the partial frame.
        drive_digit(0, 16'h4321, 4'b0010, 30);
        drive_digit(1, 16'h4321, 4'b0010, 30);
        @(negedge clk);
        anode = 4'hF; segment = 8'hFF; reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midreset_data_zero", {dataOut, pointOut}, '0);
        fv0 = fv_cnt;
        drive_digit(2, 16'h4321, 4'b0010, 30);
        drive_digit(3, 16'h4321, 4'b0010, 30);
        blank(20);
        check("midreset_no_frame", fv_cnt, fv0);
        expect_frame(16'h4321, 4'b0010);
        drive_digit(0, 16'h4321, 4'b0010, 30);
        drive_digit(1, 16'h4321, 4'b0010, 30);
        blank(S + 10);

        check("total_frames", fv_cnt, exp_frames);
        check("total_errors", err_cnt, 2);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
